// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-source write-back arbiter:
// output-register state encoding, source indices and default widths.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FULL_S0 = 2'd1,
    ST_FULL_S1 = 2'd2
  } arb_state_t;

  localparam logic SRC_0 = 1'b0;
  localparam logic SRC_1 = 1'b1;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_TAG_W  = 5;

  // Map the source index of a captured beat to the matching FULL state.
  function automatic arb_state_t full_state(input logic src);
    return (src == SRC_1) ? ST_FULL_S1 : ST_FULL_S0;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker. Purely combinational; when both requesters
// are valid the one that did not win last time is chosen. Usable by any
// controller that shares a single resource between two clients.
module rr_pick2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  input  logic enable,
  output logic grant0,
  output logic grant1
);

  // Single requester wins outright; on contention the pointer decides.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (enable) begin
      if (valid0 && valid1) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = valid0;
        grant1 = valid1;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter2.sv
// Round-robin arbiter merging two write-back sources (e.g. ALU result and
// load data) into one registered beat with a valid/ready handshake toward
// the register-file write port.
// Optional feature macro: WB_ARBITER2_LOCK_EN adds in0_lock/in1_lock so a
// source can keep priority for up to MAX_LOCK consecutive beats.
module wb_arbiter2
  import wb_arb_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int TAG_W    = DEFAULT_TAG_W,
  parameter int MAX_LOCK = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in0_valid,
  input  logic [DATA_W-1:0] in0_data,
  input  logic [TAG_W-1:0]  in0_tag,
  output logic              in0_ready,
  input  logic              in1_valid,
  input  logic [DATA_W-1:0] in1_data,
  input  logic [TAG_W-1:0]  in1_tag,
  output logic              in1_ready,
`ifdef WB_ARBITER2_LOCK_EN
  input  logic              in0_lock,
  input  logic              in1_lock,
`endif
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_src,
  input  logic              out_ready
);

  arb_state_t        state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              last_grant_q, last_grant_d;

  logic              load;
  logic              pick_en;
  logic              grant0, grant1;
  logic              xfer0, xfer1, xfer;
  logic              sel_src;
  logic [DATA_W-1:0] sel_data;
  logic [TAG_W-1:0]  sel_tag;

`ifdef WB_ARBITER2_LOCK_EN
  localparam logic [3:0] LOCK_LIMIT = 4'(MAX_LOCK);
  logic [2:0] lock_cnt_q, lock_cnt_d;
  logic [3:0] lock_cnt_inc;
  logic       sel_lock;
`endif

  // The register can take a new beat when empty or when it drains this
  // cycle; reset_n gates the picker so no ready is shown during reset.
  always_comb begin
    load    = (state_q == ST_EMPTY) || out_ready;
    pick_en = load && reset_n;
  end

  rr_pick2 u_pick (
    .valid0     (in0_valid),
    .valid1     (in1_valid),
    .last_grant (last_grant_q),
    .enable     (pick_en),
    .grant0     (grant0),
    .grant1     (grant1)
  );

  // Handshake outputs, transfer detection and the shared 2:1 data select.
  always_comb begin
    in0_ready = grant0;
    in1_ready = grant1;
    xfer0     = in0_valid && grant0;
    xfer1     = in1_valid && grant1;
    xfer      = xfer0 || xfer1;
    sel_src   = xfer1 ? SRC_1 : SRC_0;
    sel_data  = xfer1 ? in1_data : in0_data;
    sel_tag   = xfer1 ? in1_tag : in0_tag;
  end

  // Next-state for the output register, the fairness pointer and, when
  // enabled, the lock run-length counter.
  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    tag_d        = tag_q;
    last_grant_d = last_grant_q;
`ifdef WB_ARBITER2_LOCK_EN
    lock_cnt_d   = lock_cnt_q;
    sel_lock     = xfer1 ? in1_lock : in0_lock;
    lock_cnt_inc = {1'b0, lock_cnt_q} + 4'd1;
`endif
    if (load) begin
      if (xfer) begin
        state_d      = full_state(sel_src);
        data_d       = sel_data;
        tag_d        = sel_tag;
        last_grant_d = sel_src;
`ifdef WB_ARBITER2_LOCK_EN
        lock_cnt_d = 3'd0;
        if (sel_lock) begin
          if (lock_cnt_inc >= LOCK_LIMIT) begin
            last_grant_d = sel_src;
            lock_cnt_d   = 3'd0;
          end else begin
            last_grant_d = last_grant_q;
            lock_cnt_d   = lock_cnt_inc[2:0];
          end
        end
`endif
      end else begin
        state_d = ST_EMPTY;
`ifdef WB_ARBITER2_LOCK_EN
        lock_cnt_d = 3'd0;
`endif
      end
    end
  end

  // State and data registers; reset discards any held beat and points
  // priority so that source 0 wins the first contention.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_EMPTY;
      data_q       <= '0;
      tag_q        <= '0;
      last_grant_q <= SRC_1;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      tag_q        <= tag_d;
      last_grant_q <= last_grant_d;
    end
  end

`ifdef WB_ARBITER2_LOCK_EN
  // Consecutive locked-beat counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_cnt_q <= 3'd0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
    end
  end
`endif

  // Output view of the held beat; the source index follows the state.
  always_comb begin
    out_valid = (state_q != ST_EMPTY);
    out_data  = data_q;
    out_tag   = tag_q;
    out_src   = (state_q == ST_FULL_S1);
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Randomized self-checking bench for wb_arbiter2 against a transaction-level
// model: one held beat, plus which source is favoured on the next tie.
module tb_wb_arbiter2;

  logic        clk;
  logic        reset_n;
  logic        in0_valid, in1_valid;
  logic [31:0] in0_data, in1_data;
  logic [4:0]  in0_tag, in1_tag;
  logic        in0_ready, in1_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
  logic        out_src;
  logic        out_ready;
`ifdef WB_ARBITER2_LOCK_EN
  logic        in0_lock, in1_lock;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Pending beat offered by each source
  logic        s_valid [2];
  logic [31:0] s_data  [2];
  logic [4:0]  s_tag   [2];

  // Reference model
  logic        m_full;
  logic [31:0] m_data;
  logic [4:0]  m_tag;
  logic        m_src;
  int          m_prefer;

  wb_arbiter2 dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in0_valid (in0_valid),
    .in0_data  (in0_data),
    .in0_tag   (in0_tag),
    .in0_ready (in0_ready),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .in1_tag   (in1_tag),
    .in1_ready (in1_ready),
`ifdef WB_ARBITER2_LOCK_EN
    .in0_lock  (in0_lock),
    .in1_lock  (in1_lock),
`endif
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic newBeat(input int i, input int p);
    s_valid[i] = (int'($urandom_range(99)) < p);
    s_data[i]  = $urandom;
    s_tag[i]   = 5'($urandom_range(31));
  endtask

  task automatic modelReset();
    m_full   = 1'b0;
    m_data   = '0;
    m_tag    = '0;
    m_src    = 1'b0;
    m_prefer = 0;
  endtask

  // One clock: drive, check at negedge, advance model at posedge.
  task automatic applyStimulus(input int p0, input int p1, input int pr);
    bit load, e0, e1;
    int p [2];
    p[0] = p0;
    p[1] = p1;
    in0_valid = s_valid[0];
    in0_data  = s_data[0];
    in0_tag   = s_tag[0];
    in1_valid = s_valid[1];
    in1_data  = s_data[1];
    in1_tag   = s_tag[1];
    out_ready = (int'($urandom_range(99)) < pr);
    load = !m_full || out_ready;
    e0 = 1'b0;
    e1 = 1'b0;
    if (load) begin
      if (s_valid[0] && s_valid[1]) begin
        if (m_prefer == 0) e0 = 1'b1;
        else e1 = 1'b1;
      end else if (s_valid[0]) e0 = 1'b1;
      else if (s_valid[1]) e1 = 1'b1;
    end
    @(negedge clk);
    checkOutput("in0_ready", 32'(in0_ready), 32'(e0));
    checkOutput("in1_ready", 32'(in1_ready), 32'(e1));
    checkOutput("out_valid", 32'(out_valid), 32'(m_full));
    if (m_full) begin
      checkOutput("out_data", out_data, m_data);
      checkOutput("out_tag", 32'(out_tag), 32'(m_tag));
      checkOutput("out_src", 32'(out_src), 32'(m_src));
    end
    @(posedge clk);
    if (load) begin
      if (e0 || e1) begin
        m_full   = 1'b1;
        m_src    = e1;
        m_data   = e1 ? s_data[1] : s_data[0];
        m_tag    = e1 ? s_tag[1] : s_tag[0];
        m_prefer = e1 ? 0 : 1;
      end else begin
        m_full = 1'b0;
      end
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      if ((i == 0 && e0) || (i == 1 && e1) || !s_valid[i]) newBeat(i, p[i]);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    out_ready = 1'b0;
`ifdef WB_ARBITER2_LOCK_EN
    in0_lock  = 1'b0;
    in1_lock  = 1'b0;
`endif
    s_valid[0] = 1'b1; s_data[0] = 32'hAAAA0000; s_tag[0] = 5'd3;
    s_valid[1] = 1'b1; s_data[1] = 32'h55550000; s_tag[1] = 5'd9;
    in0_valid = 1'b1; in0_data = s_data[0]; in0_tag = s_tag[0];
    in1_valid = 1'b1; in1_data = s_data[1]; in1_tag = s_tag[1];
    modelReset();
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", out_data, 32'd0);
    checkOutput("rst_out_tag", 32'(out_tag), 32'd0);
    checkOutput("rst_out_src", 32'(out_src), 32'd0);
    checkOutput("rst_in0_ready", 32'(in0_ready), 32'd0);
    checkOutput("rst_in1_ready", 32'(in1_ready), 32'd0);
    reset_n = 1'b1;
    $display("[TB] alternation with both sources busy");
    for (int i = 0; i < 8; i++) applyStimulus(100, 100, 100);
    $display("[TB] downstream stall");
    for (int i = 0; i < 3; i++) applyStimulus(100, 100, 0);
    for (int i = 0; i < 4; i++) applyStimulus(100, 100, 100);
    $display("[TB] source 1 only");
    for (int i = 0; i < 10; i++) applyStimulus(0, 100, 100);
    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) applyStimulus(60, 60, 70);
    $display("[TB] reset mid-stream");
    applyStimulus(100, 100, 0);
    applyStimulus(100, 100, 0);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_in0_ready", 32'(in0_ready), 32'd0);
    checkOutput("mid_rst_in1_ready", 32'(in1_ready), 32'd0);
    modelReset();
    s_valid[0] = 1'b1;
    s_valid[1] = 1'b1;
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 20; i++) applyStimulus(100, 100, 80);
    for (int i = 0; i < 300; i++) applyStimulus(50, 80, 50);
    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
